// File: rtl/game_round_controller.sv
// game_round_controller: game-level sequencer around the round master FSM.
// Tracks score, level, lives and the win count toward the next level.
// Gates the master FSM with game_enable and pulses new_round when a round starts.
// Optional feature: define GAME_ROUND_CTRL_BONUS_LIFE_EN to award one life
// (saturating at 3) on every level-up.

module game_round_controller #(
    parameter int unsigned START_LIVES    = 3,
    parameter int unsigned WINS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_key,
    input  logic       round_end,
    input  logic       round_won,
    input  logic       timer_running,
    output logic       game_enable,
    output logic       new_round,
    output logic [2:0] level,
    output logic [3:0] target_speed,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StWaitEnd,
        StOver
    } state_e;

    localparam logic [1:0] StartLives   = 2'(START_LIVES);
    localparam logic [3:0] WinsPerLevel = 4'(WINS_PER_LEVEL);
    localparam logic [2:0] MaxLevel     = 3'(MAX_LEVEL);

    state_e     state;
    logic       start_prev;
    logic [3:0] win_cnt;
    logic       start_edge;
    logic       level_up;

    assign start_edge   = start_key & ~start_prev;
    // A win that completes the current level's quota.
    assign level_up     = round_won && ((win_cnt + 4'd1) == WinsPerLevel);
    assign target_speed = {1'b0, level} + 4'd1;

    // Game sequencer: state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            // Reset as if the key were already down, so a key held through
            // reset must be released before it can start a game.
            start_prev  <= 1'b1;
            win_cnt     <= 4'd0;
            score       <= 8'd0;
            level       <= 3'd0;
            lives       <= 2'd0;
            game_enable <= 1'b0;
            new_round   <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_prev <= start_key;
            new_round  <= 1'b0;
            case (state)
                StIdle, StOver: begin
                    if (start_edge) begin
                        state       <= StPlay;
                        score       <= 8'd0;
                        level       <= 3'd0;
                        win_cnt     <= 4'd0;
                        lives       <= StartLives;
                        game_enable <= 1'b1;
                        new_round   <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
                StPlay: begin
                    // A start edge in this state is dropped, even alongside round_end.
                    if (round_end) begin
                        state       <= StWaitEnd;
                        game_enable <= 1'b0;
                        if (round_won) begin
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
                            if (level_up) begin
                                win_cnt <= 4'd0;
                                if (level < MaxLevel) begin
                                    level <= level + 3'd1;
                                end
`ifdef GAME_ROUND_CTRL_BONUS_LIFE_EN
                                if (lives != 2'd3) begin
                                    lives <= lives + 2'd1;
                                end
`endif
                            end else begin
                                win_cnt <= win_cnt + 4'd1;
                            end
                        end else if (lives != 2'd0) begin
                            lives <= lives - 2'd1;
                        end
                    end
                end
                StWaitEnd: begin
                    if (!timer_running) begin
                        if (lives == 2'd0) begin
                            state     <= StOver;
                            game_over <= 1'b1;
                        end else begin
                            state       <= StPlay;
                            game_enable <= 1'b1;
                            new_round   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= StIdle;
                    game_enable <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed stimulus against a behavioural model of the
// game rules (score/level/lives derived from win and loss counts), compared on
// every falling clock edge, plus hand-computed literal expectations.
// Define GAME_ROUND_CTRL_BONUS_LIFE_EN for both bench and RTL to cover the bonus-life build.

module tb_game_round_controller;

    localparam int START = 3;
    localparam int WINS  = 4;
    localparam int MAXL  = 7;

    // Game phases of the model.
    localparam int MIdle = 0;
    localparam int MPlay = 1;
    localparam int MWait = 2;
    localparam int MOver = 3;

    logic       clk;
    logic       reset;
    logic       start_key;
    logic       round_end;
    logic       round_won;
    logic       timer_running;
    logic       game_enable;
    logic       new_round;
    logic [2:0] level;
    logic [3:0] target_speed;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    int n_checks = 0;
    int n_err    = 0;
    int nr_cnt   = 0;
    int nr_base  = 0;

    // Model state.
    int   m_mode;
    int   m_wins;
    int   m_lives;
    logic m_new;
    logic m_key_prev;

    int c_level;

    game_round_controller #(
        .START_LIVES   (START),
        .WINS_PER_LEVEL(WINS),
        .MAX_LEVEL     (MAXL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_key    (start_key),
        .round_end    (round_end),
        .round_won    (round_won),
        .timer_running(timer_running),
        .game_enable  (game_enable),
        .new_round    (new_round),
        .level        (level),
        .target_speed (target_speed),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = MIdle;
        m_wins     = 0;
        m_lives    = 0;
        m_new      = 1'b0;
        m_key_prev = 1'b1;
    endtask

    // Game rules applied to the inputs seen at one rising edge.
    task automatic model_edge();
        logic key_edge;
        key_edge   = start_key && !m_key_prev;
        m_key_prev = start_key;
        m_new      = 1'b0;
        case (m_mode)
            MIdle, MOver: begin
                if (key_edge) begin
                    m_mode  = MPlay;
                    m_wins  = 0;
                    m_lives = START;
                    m_new   = 1'b1;
                end
            end
            MPlay: begin
                if (round_end) begin
                    m_mode = MWait;
                    if (round_won) begin
                        m_wins++;
`ifdef GAME_ROUND_CTRL_BONUS_LIFE_EN
                        if ((m_wins % WINS) == 0 && m_lives < 3) m_lives++;
`endif
                    end else if (m_lives > 0) begin
                        m_lives--;
                    end
                end
            end
            MWait: begin
                if (!timer_running) begin
                    if (m_lives == 0) begin
                        m_mode = MOver;
                    end else begin
                        m_mode = MPlay;
                        m_new  = 1'b1;
                    end
                end
            end
            default: m_mode = MIdle;
        endcase
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            c_level = m_wins / WINS;
            if (c_level > MAXL) c_level = MAXL;
            check("game_enable", 32'(game_enable), 32'(m_mode == MPlay));
            check("game_over", 32'(game_over), 32'(m_mode == MOver));
            check("new_round", 32'(new_round), 32'(m_new));
            check("score", 32'(score), 32'((m_wins > 255) ? 255 : m_wins));
            check("level", 32'(level), 32'(c_level));
            check("target_speed", 32'(target_speed), 32'(c_level + 1));
            check("lives", 32'(lives), 32'(m_lives));
            if (new_round) nr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        start_key     = 1'b0;
        round_end     = 1'b0;
        round_won     = 1'b0;
        timer_running = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // One round: resolve, timer busy two cycles (with optional stray
    // round_end while waiting), timer drops.
    task automatic play_round(input logic won, input logic extra_end, input logic key);
        round_end = 1'b1;
        round_won = won;
        start_key = key;
        step();
        round_end     = extra_end;
        round_won     = extra_end;
        start_key     = 1'b0;
        timer_running = 1'b1;
        step();
        round_end = 1'b0;
        round_won = 1'b0;
        step();
        timer_running = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        start_key     = 1'b0;
        round_end     = 1'b0;
        round_won     = 1'b0;
        timer_running = 1'b0;
        model_reset();
        step();
        check("rst_game_enable", 32'(game_enable), 32'd0);
        check("rst_new_round", 32'(new_round), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_lives", 32'(lives), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        step();
        reset = 1'b0;
        idle_steps(2);

        // Start edge: first PLAY cycle carries new_round; held key counts once.
        start_key = 1'b1;
        step();
        check("start_new_round", 32'(new_round), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_score", 32'(score), 32'd0);
        check("start_speed", 32'(target_speed), 32'd1);
        step();
        step();
        check("held_key_new_round", 32'(new_round), 32'd0);
        idle_steps(1);
        nr_base = nr_cnt;

        // Four wins: first level-up.
        for (int i = 0; i < 4; i++) play_round(1'b1, 1'b0, 1'b0);
        idle_steps(1);
        check("win4_score", 32'(score), 32'd4);
        check("win4_level", 32'(level), 32'd1);
        check("win4_speed", 32'(target_speed), 32'd2);
        check("win4_new_rounds", 32'(nr_cnt - nr_base), 32'd4);
        check("win4_lives", 32'(lives), 32'd3);

        // Stray round_end during WAIT_END is ignored.
        play_round(1'b1, 1'b1, 1'b0);
        check("wait_end_ignored_score", 32'(score), 32'd5);
        // Start edge together with round_end in PLAY: round_end wins.
        play_round(1'b1, 1'b0, 1'b1);
        check("start_dropped_score", 32'(score), 32'd6);
        check("start_dropped_enable", 32'(game_enable), 32'd1);

        // Three losses drain the lives and end the game.
        play_round(1'b0, 1'b0, 1'b0);
        check("loss1_lives", 32'(lives), 32'd2);
        play_round(1'b0, 1'b0, 1'b0);
        check("loss2_lives", 32'(lives), 32'd1);
        play_round(1'b0, 1'b0, 1'b0);
        check("loss3_lives", 32'(lives), 32'd0);
        check("over_game_over", 32'(game_over), 32'd1);
        check("over_game_enable", 32'(game_enable), 32'd0);
        check("over_score_hold", 32'(score), 32'd6);
        check("over_level_hold", 32'(level), 32'd1);

        // round_end in OVER is ignored.
        round_end = 1'b1;
        round_won = 1'b1;
        step();
        idle_steps(2);
        check("over_round_end_score", 32'(score), 32'd6);

        // Restart from OVER.
        start_key = 1'b1;
        step();
        check("restart_score", 32'(score), 32'd0);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_enable", 32'(game_enable), 32'd1);
        check("restart_game_over", 32'(game_over), 32'd0);
        idle_steps(1);

        // 32 wins saturate the level; keep winning past saturation.
        for (int i = 0; i < 32; i++) play_round(1'b1, 1'b0, 1'b0);
        check("sat_level", 32'(level), 32'd7);
        check("sat_speed", 32'(target_speed), 32'd8);
        check("sat_score", 32'(score), 32'd32);
        for (int i = 0; i < 4; i++) play_round(1'b1, 1'b0, 1'b0);
        check("sat_level_hold", 32'(level), 32'd7);
        check("sat_score_36", 32'(score), 32'd36);

        // Asynchronous reset in WAIT_END.
        round_end = 1'b1;
        round_won = 1'b1;
        step();
        round_end     = 1'b0;
        round_won     = 1'b0;
        timer_running = 1'b1;
        step();
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_enable", 32'(game_enable), 32'd0);
        check("async_rst_new_round", 32'(new_round), 32'd0);
        check("async_rst_game_over", 32'(game_over), 32'd0);
        check("async_rst_score", 32'(score), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_lives", 32'(lives), 32'd0);
        @(negedge clk);

        // Key held through reset release is not a start edge.
        timer_running = 1'b0;
        start_key     = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check("held_rst_enable", 32'(game_enable), 32'd0);
        check("held_rst_new_round", 32'(new_round), 32'd0);
        start_key = 1'b0;
        step();
        start_key = 1'b1;
        step();
        check("repress_enable", 32'(game_enable), 32'd1);
        check("repress_new_round", 32'(new_round), 32'd1);
        idle_steps(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
